// File: rtl/cycle_controller_pkg.sv
// rtl/cycle_controller_pkg.sv - shared opcode, class and Q-phase definitions for the cycle controller
package cycle_controller_pkg;

    localparam logic [1:0] BYTE = 2'b00;
    localparam logic [1:0] BIT  = 2'b01;
    localparam logic [1:0] CTRL = 2'b10;
    localparam logic [1:0] LIT  = 2'b11;

    // Byte-class opcodes live in ir[13:8]; OP_MISC groups NOP, RETURN and MOVWF
    localparam logic [5:0] OP_MISC   = 6'b000000;
    localparam logic [5:0] OP_DECFSZ = 6'b001011;
    localparam logic [5:0] OP_INCFSZ = 6'b001111;
    localparam logic [6:0] OP_MOVWF  = 7'b0000001;
    localparam logic [1:0] OP_BTFSC  = 2'b10;
    localparam logic [1:0] OP_BTFSS  = 2'b11;
    localparam logic [2:0] OP_CALL   = 3'b100;
    localparam logic [2:0] OP_GOTO   = 3'b101;
    localparam logic [3:0] OP_RETLW  = 4'b1101;

    localparam logic [13:0] NOP_WORD    = 14'h0000;
    localparam logic [13:0] RETURN_WORD = 14'h0008;

    typedef enum logic [1:0] {
        Q1 = 2'd0,
        Q2 = 2'd1,
        Q3 = 2'd2,
        Q4 = 2'd3
    } q_phase_e;

endpackage

// File: rtl/cycle_controller_call_stack.sv
// rtl/cycle_controller_call_stack.sv - circular hardware call stack with sticky overflow/underflow flags
module call_stack #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_top,
    output logic             o_ovf,
    output logic             o_unf
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_dec;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic             r_unf;

    // r_ptr is the next free slot, so the top entry sits one below it (wrapping)
    assign w_ptr_dec = r_ptr - PTR_W'(1);
    assign o_top     = r_mem[w_ptr_dec];
    assign o_ovf     = r_ovf;
    assign o_unf     = r_unf;

    always_ff @(posedge clk) begin
        if (!reset && i_push) begin
            r_mem[r_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else if (i_push) begin
            r_ptr <= r_ptr + PTR_W'(1);
            if (r_cnt == CNT_W'(DEPTH)) begin
                r_ovf <= 1'b1;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else if (i_pop) begin
            r_ptr <= w_ptr_dec;
            if (r_cnt == '0) begin
                r_unf <= 1'b1;
            end else begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/cycle_controller.sv
// rtl/cycle_controller.sv - Q1-Q4 instruction-cycle sequencer owning pc, ir, call stack and write strobes
module cycle_controller
    import cycle_controller_pkg::*;
#(
    parameter int              PC_W         = 12,
    parameter int              STACK_DEPTH  = 8,
    parameter logic [PC_W-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [13:0]     instr_in,
    input  logic            alu_zero,
    input  logic            bit_val,
    output logic [1:0]      q_phase,
    output logic [PC_W-1:0] pc,
    output logic [13:0]     ir,
    output logic            nop_cycle,
    output logic            w_we,
    output logic            f_we,
    output logic            stack_ovf,
    output logic            stack_unf
);
    q_phase_e        r_q;
    q_phase_e        w_q_next;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_next_pc;
    logic [PC_W-1:0] w_stack_top;
    logic [13:0]     r_ir;
    logic            r_nop;
    logic            w_goto, w_call, w_ret, w_retlw, w_fsz, w_btfsc, w_btfss;
    logic            w_flush, w_exec_q4, w_push, w_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= Q1;
        end else begin
            r_q <= w_q_next;
        end
    end

    always_comb begin
        w_q_next = Q1;
        case (r_q)
            Q1: w_q_next = Q2;
            Q2: w_q_next = Q3;
            Q3: w_q_next = Q4;
            Q4: w_q_next = Q1;
            default: w_q_next = Q1;
        endcase
    end

    assign w_goto  = (r_ir[13:11] == OP_GOTO);
    assign w_call  = (r_ir[13:11] == OP_CALL);
    assign w_ret   = (r_ir == RETURN_WORD);
    assign w_retlw = (r_ir[13:10] == OP_RETLW);
    assign w_fsz   = (r_ir[13:8] == OP_DECFSZ) || (r_ir[13:8] == OP_INCFSZ);
    assign w_btfsc = (r_ir[13:12] == BIT) && (r_ir[11:10] == OP_BTFSC);
    assign w_btfss = (r_ir[13:12] == BIT) && (r_ir[11:10] == OP_BTFSS);

    // A flushed cycle never evaluates its (NOP) word, so every flush source is gated by r_nop
    assign w_flush = !r_nop && (w_goto || w_call || w_ret || w_retlw ||
                                (w_fsz && alu_zero) ||
                                (w_btfsc && !bit_val) ||
                                (w_btfss && bit_val));

    assign w_exec_q4 = (r_q == Q4) && !r_nop;
    assign w_push    = w_exec_q4 && w_call;
    assign w_pop     = w_exec_q4 && (w_ret || w_retlw);

    always_comb begin
        w_next_pc = r_pc + PC_W'(1);
        if (!r_nop) begin
            if (w_goto || w_call) begin
                w_next_pc = PC_W'(r_ir[10:0]);
            end else if (w_ret || w_retlw) begin
                w_next_pc = w_stack_top;
            end
        end
    end

    always_comb begin
        w_we = 1'b0;
        f_we = 1'b0;
        if (w_exec_q4) begin
            case (r_ir[13:12])
                BYTE: begin
                    if (r_ir[13:8] == OP_MISC) begin
                        f_we = (r_ir[13:7] == OP_MOVWF);
                    end else begin
                        f_we = r_ir[7];
                        w_we = !r_ir[7];
                    end
                end
                BIT:     f_we = !r_ir[11];
                LIT:     w_we = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc  <= RESET_VECTOR;
            r_ir  <= NOP_WORD;
            r_nop <= 1'b1;
        end else if (r_q == Q4) begin
            r_ir  <= w_flush ? NOP_WORD : instr_in;
            r_nop <= w_flush;
            r_pc  <= w_next_pc;
        end
    end

    // r_pc already points past the CALL, so it is pushed as the return address
    call_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (PC_W)
    ) u_call_stack (
        .clk    (clk),
        .reset  (reset),
        .i_push (w_push),
        .i_pop  (w_pop),
        .i_data (r_pc),
        .o_top  (w_stack_top),
        .o_ovf  (stack_ovf),
        .o_unf  (stack_unf)
    );

    assign q_phase   = r_q;
    assign pc        = r_pc;
    assign ir        = r_ir;
    assign nop_cycle = r_nop;

endmodule

// File: tb/tb_cycle_controller.sv
// tb/tb_cycle_controller.sv - directed self-checking bench for cycle_controller
module tb_cycle_controller;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [13:0] instr_in;
    logic        alu_zero = 1'b0;
    logic        bit_val = 1'b0;
    logic [1:0]  q_phase;
    logic [11:0] pc;
    logic [13:0] ir;
    logic        nop_cycle, w_we, f_we, stack_ovf, stack_unf;

    logic [13:0] mem [0:4095];
    int n_tests = 0;
    int n_fail = 0;
    int cnt_w = 0;
    int cnt_f = 0;
    int bad_strobe = 0;
    int clk_cnt = 0;
    int cur = 0;

    cycle_controller dut (
        .clk       (clk),
        .reset     (reset),
        .instr_in  (instr_in),
        .alu_zero  (alu_zero),
        .bit_val   (bit_val),
        .q_phase   (q_phase),
        .pc        (pc),
        .ir        (ir),
        .nop_cycle (nop_cycle),
        .w_we      (w_we),
        .f_we      (f_we),
        .stack_ovf (stack_ovf),
        .stack_unf (stack_unf)
    );

    assign instr_in = mem[pc];

    always #5 clk = ~clk;
    always @(posedge clk) clk_cnt++;

    always @(negedge clk) begin
        if (w_we) cnt_w++;
        if (f_we) cnt_f++;
        if ((w_we || f_we) && q_phase != 2'd3) bad_strobe++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mem(input logic [13:0] v);
        for (int a = 0; a < 4096; a++) mem[a] = v;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cur = 0;
    endtask

    task automatic goto_cycle(input int c);
        repeat (4 * (c - cur)) @(negedge clk);
        cur = c;
    endtask

    task automatic wait_ir(input string tag, input logic [13:0] v, output int t);
        int n = 0;
        while (ir !== v && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk(tag, ir, v);
        t = clk_cnt;
    endtask

    initial begin
        int w0, f0, t0, t1;

        // Reset state and straight-line MOVLW code
        clear_mem(14'h0000);
        mem[0] = 14'h3011; mem[1] = 14'h3022; mem[2] = 14'h3033;
        do_reset();
        w0 = cnt_w;
        chk("rst_q", q_phase, 0);
        chk("rst_pc", pc, 0);
        chk("rst_ir", ir, 0);
        chk("rst_nop", nop_cycle, 1);
        chk("rst_we", {w_we, f_we}, 0);
        chk("rst_flags", {stack_ovf, stack_unf}, 0);
        for (int p = 1; p <= 4; p++) begin
            @(negedge clk);
            chk("q_seq", q_phase, p % 4);
        end
        cur = 1;
        chk("c1_pc", pc, 1);
        chk("c1_ir", ir, 14'h3011);
        chk("c1_nop", nop_cycle, 0);
        goto_cycle(2); chk("c2_pc", pc, 2);
        goto_cycle(3); chk("c3_pc", pc, 3);
        goto_cycle(4); chk("lin_wcnt", cnt_w - w0, 3);

        // GOTO 0x020 at address 5
        clear_mem(14'h0000);
        for (int a = 0; a < 5; a++) mem[a] = 14'h3000 | 14'(a);
        mem[5] = 14'h2820; mem[6] = 14'h3066; mem[32] = 14'h3077; mem[33] = 14'h3078;
        do_reset();
        wait_ir("goto_seen", 14'h2820, t0);
        w0 = cnt_w;
        repeat (4) @(negedge clk);
        chk("goto_nop", nop_cycle, 1);
        chk("goto_flush_ir", ir, 0);
        chk("goto_fetch", pc, 12'h020);
        wait_ir("goto_target", 14'h3077, t1);
        chk("goto_clks", t1 - t0, 8);
        chk("goto_pc_after", pc, 12'h021);
        chk("goto_no_we", cnt_w - w0, 0);

        // CALL 0x100 at 0x010, RETURN at 0x100
        clear_mem(14'h0000);
        mem[16] = 14'h2100; mem[17] = 14'h3011; mem[256] = 14'h0008; mem[257] = 14'h3055;
        do_reset();
        w0 = cnt_w; f0 = cnt_f;
        goto_cycle(17); chk("call_ir", ir, 14'h2100);
        goto_cycle(18); chk("call_nop", nop_cycle, 1); chk("call_pc", pc, 12'h100);
        goto_cycle(19); chk("ret_ir", ir, 14'h0008); chk("ret_nop0", nop_cycle, 0);
        goto_cycle(20); chk("ret_nop", nop_cycle, 1); chk("ret_pc", pc, 12'h011);
        goto_cycle(21); chk("ret_landed", ir, 14'h3011);
        chk("call_no_we", (cnt_w - w0) + (cnt_f - f0), 0);
        chk("call_flags", {stack_ovf, stack_unf}, 0);

        // DECFSZ skip / no-skip
        clear_mem(14'h0000);
        mem[0] = 14'h0BA0; mem[1] = 14'h3001; mem[2] = 14'h0B20; mem[3] = 14'h3003; mem[4] = 14'h3004;
        alu_zero = 1'b1;
        do_reset();
        goto_cycle(1); chk("dec1_ir", ir, 14'h0BA0); w0 = cnt_w; f0 = cnt_f;
        goto_cycle(2);
        chk("dec1_fwe", cnt_f - f0, 1); chk("dec1_wwe", cnt_w - w0, 0);
        chk("dec1_skip", nop_cycle, 1); chk("dec1_pc", pc, 2);
        alu_zero = 1'b0;
        goto_cycle(3); chk("dec0_ir", ir, 14'h0B20); w0 = cnt_w; f0 = cnt_f;
        goto_cycle(4);
        chk("dec0_wwe", cnt_w - w0, 1); chk("dec0_fwe", cnt_f - f0, 0);
        chk("dec0_noskip", nop_cycle, 0); chk("dec0_next", ir, 14'h3003);

        // BTFSS / BTFSC with bit_val = 1, then BSF
        clear_mem(14'h0000);
        mem[0] = 14'h1D85; mem[1] = 14'h3001; mem[2] = 14'h1985; mem[3] = 14'h3003; mem[4] = 14'h1405;
        bit_val = 1'b1;
        do_reset();
        goto_cycle(1); chk("btfss_ir", ir, 14'h1D85); w0 = cnt_w; f0 = cnt_f;
        goto_cycle(2); chk("btfss_skip", nop_cycle, 1); chk("btfss_pc", pc, 2);
        goto_cycle(3); chk("btfsc_ir", ir, 14'h1985);
        goto_cycle(4); chk("btfsc_noskip", nop_cycle, 0); chk("btfsc_next", ir, 14'h3003);
        chk("bt_no_we", (cnt_w - w0) + (cnt_f - f0), 0);
        goto_cycle(5); chk("bsf_ir", ir, 14'h1405); f0 = cnt_f;
        goto_cycle(6); chk("bsf_fwe", cnt_f - f0, 1);
        bit_val = 1'b0;

        // Nine nested CALLs then nine RETURNs, then reset at Q3
        clear_mem(14'h0000);
        for (int i = 0; i < 9; i++) begin
            mem[2 * i]     = 14'h2000 | 14'(2 * i + 2);
            mem[2 * i + 1] = 14'h0008;
        end
        mem[18] = 14'h0008;
        do_reset();
        goto_cycle(17); chk("ovf_before", stack_ovf, 0);
        goto_cycle(18); chk("ovf_after", stack_ovf, 1);
        goto_cycle(34); chk("ret8_pc", pc, 3);
        goto_cycle(35); chk("unf_before", stack_unf, 0);
        goto_cycle(36); chk("unf_after", stack_unf, 1); chk("ovf_sticky", stack_ovf, 1);
        clear_mem(14'h3099);
        goto_cycle(37);
        chk("pre_rst_ir", ir, 14'h3099);
        chk("pre_rst_nop", nop_cycle, 0);
        w0 = cnt_w;
        repeat (2) @(negedge clk);
        chk("pre_rst_q", q_phase, 2);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_pc", pc, 0);
        chk("mid_rst_q", q_phase, 0);
        chk("mid_rst_flags", {stack_ovf, stack_unf}, 0);
        chk("mid_rst_no_we", cnt_w - w0, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        chk("strobe_phase", bad_strobe, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cycle_controller.md
Name: cycle_controller

Overview:
- Instruction-cycle sequencer for the PIC-style core. It divides `clk` into four phases (Q1–Q4) and owns the program counter and the instruction register.
- It also owns the 8-level hardware call stack, and generates the write strobes for the W register and the file registers.
- It resolves GOTO, CALL, RETURN, RETLW and the skip instructions by flushing the prefetched word, so those instructions take two instruction cycles.
- It sits between flash program memory and the decode/ALU/register datapath.

Parameters:
- PC_W, 12, program counter width in bits.
- STACK_DEPTH, 8, number of call-stack entries (power of 2).
- RESET_VECTOR, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock; one Q phase per cycle.
- reset  in  1  synchronous, active-high.
- instr_in  in  14  word fetched from program memory at address pc.
- alu_zero  in  1  ALU result equals zero (used by DECFSZ/INCFSZ); sampled on the Q4 edge.
- bit_val  in  1  value of the addressed bit (used by BTFSC/BTFSS); sampled on the Q4 edge.
- q_phase  out  2  current phase: 0 = Q1 … 3 = Q4.
- pc  out  PC_W  fetch address presented to program memory.
- ir  out  14  instruction currently executing.
- nop_cycle  out  1  the current cycle is a flushed NOP.
- w_we  out  1  W register write strobe.
- f_we  out  1  file register write strobe.
- stack_ovf  out  1  sticky flag: push while stack full.
- stack_unf  out  1  sticky flag: pop while stack empty.

Behaviour:
- Reset:
  - q_phase = 0, pc = RESET_VECTOR, ir = 14'h0000, nop_cycle = 1.
  - w_we = f_we = 0; stack pointer and entry count = 0; stack_ovf = stack_unf = 0.
  - Reset mid-cycle aborts the current instruction: no strobe is issued and no stack change occurs.
- Phase counter: q_phase increments every clk and wraps 3 → 0. One instruction cycle = 4 clk.
- Instruction-cycle commit, at the clk edge where q_phase == 3:
  - ir is loaded with instr_in, or with 14'h0000 if the flush condition holds. nop_cycle is loaded with that flush condition.
  - pc is loaded with next_pc.
- next_pc, evaluated only when nop_cycle = 0 (otherwise pc + 1):
  - GOTO (10 1kkk…): target = ir[10:0], zero-extended to PC_W.
  - CALL (10 0kkk…): push pc, then target = ir[10:0]. The pushed pc is already the return address.
  - RETURN (00 0000 0000 1000) and RETLW (11 01xx…): pop.
  - All other instructions: pc + 1, wrapping modulo 2^PC_W.
- Flush condition, when nop_cycle = 0:
  - GOTO, CALL, RETURN or RETLW always flush.
  - DECFSZ (00 1011) or INCFSZ (00 1111) flush when alu_zero = 1.
  - BTFSC (01 10) flushes when bit_val = 0; BTFSS (01 11) flushes when bit_val = 1.
- A flushed cycle executes nothing: no strobes, no stack activity, no skip or branch evaluation.
- Write strobes are high only while q_phase == 3 and nop_cycle = 0, for exactly one clk:
  - Byte class (ir[13:12] = 00), excluding NOP, RETURN and the skip-only encodings: ir[7] = 1 asserts f_we, ir[7] = 0 asserts w_we. MOVWF always asserts f_we.
  - DECFSZ and INCFSZ write per ir[7] like other byte-class instructions.
  - Bit class: BCF and BSF assert f_we; BTFSC and BTFSS assert neither.
  - Literal class (11): w_we, which includes RETLW.
  - Control class (10): no strobe.
- Stack:
  - Circular buffer of STACK_DEPTH entries with a pointer that wraps.
  - Pushing when the count equals STACK_DEPTH overwrites the oldest entry and sets stack_ovf.
  - Popping when the count is 0 returns the entry at the wrapped pointer and sets stack_unf.
  - The count saturates at 0 and at STACK_DEPTH.
  - Both flags are sticky and cleared only by reset.

Decomposition:
- Shared package holds:
  - Opcode-class constants: BYTE = 2'b00, BIT = 2'b01, CTRL = 2'b10, LIT = 2'b11.
  - Opcode constants: DECFSZ, INCFSZ, BTFSC, BTFSS, RETLW and MOVWF codes; NOP/RETURN encodings; NOP_WORD = 14'h0000.
  - Q-phase enum: Q1–Q4.
- One sub-module, call_stack: push/pop/data plus ovf/unf flags, parameterised by depth and width.

Test Plan:
- Reset, then straight-line code of 3 MOVLW words → pc reads 0, 1, 2, 3 on successive q_phase = 0. w_we pulses once per cycle, with no pulse in the first (flushed) cycle.
- GOTO 0x020 at address 5 → the word at address 6 is loaded as a NOP (nop_cycle = 1, no strobes), the next fetch is from 0x020, and 8 clk elapse between GOTO commit and the target instruction commit.
- CALL 0x100 at address 0x010, then RETURN at 0x100 → the stack holds 0x011, pc returns to 0x011, and each of CALL and RETURN is followed by one flushed cycle.
- DECFSZ with alu_zero = 1 → the next instruction is flushed. The same instruction with alu_zero = 0 → no flush. f_we follows ir[7] in both cases.
- BTFSS with bit_val = 1 → skip; BTFSC with bit_val = 1 → no skip. Neither asserts any write strobe.
- 9 nested CALLs → stack_ovf = 1 after the 9th. Then 9 RETURNs → stack_unf = 1. A reset asserted at q_phase = 2 clears both flags and sets pc = 0 with no strobe.
